filter2d_pp_buf: RTL and testbench

Parametrised ping-pong frame buffer feeding the 2D filter engine. It is the successor to the fixed 256x256 8-bit buffer and adds:
- generic pixel width and image size, including non-power-of-two dimensions;
- consumer release handshake (`rd_done`) with queued-frame tracking;
- input back-pressure (`i_rdy`);
- sticky overflow and start-of-frame error flags.

It sits between the pixel stream source and the filter core. Two `mem_single` banks alternate between write and read roles.

---
 rtl/filter2d_pp_buf.sv | 211 +++++++++++++++++++++
 tb/tb_filter2d_pp_buf.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter2d_pp_buf.sv
// Ping-pong frame buffer between the pixel stream source and the 2D filter.
// Two banks alternate: one fills from the stream while the other is read.

module mem_single #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

module filter2d_pp_buf #(
  parameter int  DW    = 8,
  parameter int  IMG_W = 256,
  parameter int  IMG_H = 256,
  localparam int AW    = $clog2(IMG_W * IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_strb,
  input  logic          i_sof,
  input  logic [DW-1:0] i_data,
  output logic          i_rdy,
  output logic          start,
  input  logic          mem_rd,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic          rd_done,
  output logic          o_ovf,
  output logic          o_sof_err
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int XW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [XW-1:0] XMAX = XW'(IMG_W - 1);
  localparam logic [YW-1:0] YMAX = YW'(IMG_H - 1);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [1:0]    full_q, full_d;
  logic          pend_q, pend_d;
  logic          start_q, start_d;
  logic          ovf_q, ovf_d;
  logic          sof_err_q, sof_err_d;
  logic          rd_sel_q;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic          acc;
  logic          cmpl;
  logic          rel;
  logic          at_org;
  logic          sof_mid;
  logic          last;
  logic          oth_bank;
  logic [AW-1:0] pix_addr;
  logic          rd_ok;
  logic          we0, we1;
  logic          re0, re1;
  logic [DW-1:0] rdata0, rdata1;

  assign i_rdy    = ~full_q[wr_bank_q] & ~pend_q;
  assign acc      = i_strb & i_rdy;
  assign cmpl     = pend_q & we_q;
  assign rel      = rd_done & full_q[rd_bank_q];
  assign at_org   = (x_q == '0) && (y_q == '0);
  assign sof_mid  = i_sof & ~at_org;
  assign last     = (x_q == XMAX) && (y_q == YMAX);
  assign oth_bank = ~rd_bank_q;
  assign pix_addr = AW'(y_q) * AW'(IMG_W)
                  + AW'(x_q);

  // Stream side: pixel counters and registered write stage
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    pend_d    = pend_q & ~cmpl;
    we_d      = acc;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    sof_err_d = sof_err_q | (acc & sof_mid);
    ovf_d     = ovf_q | (i_strb & ~i_rdy);
    if (acc) begin
      wdata_d = i_data;
      if (sof_mid) begin
        waddr_d = '0;
        x_d     = XW'(1);
        y_d     = '0;
      end else begin
        waddr_d = pix_addr;
        pend_d  = last;
        if (x_q == XMAX) begin
          x_d = '0;
          y_d = (y_q == YMAX) ? '0
              : y_q + YW'(1);
        end else begin
          x_d = x_q + XW'(1);
        end
      end
    end
  end

  // Bank roles; the other bank may complete in the release cycle
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    if (cmpl) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end
    if (rel) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
    start_d = (cmpl & (wr_bank_q == rd_bank_q))
            | (rel & full_d[oth_bank]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q       <= '0;
      y_q       <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
      pend_q    <= 1'b0;
      start_q   <= 1'b0;
      ovf_q     <= 1'b0;
      sof_err_q <= 1'b0;
      rd_sel_q  <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      pend_q    <= pend_d;
      start_q   <= start_d;
      ovf_q     <= ovf_d;
      sof_err_q <= sof_err_d;
      rd_sel_q  <= rd_bank_q;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign rd_ok = mem_rd & full_q[rd_bank_q];
  assign re0   = rd_ok & ~rd_bank_q;
  assign re1   = rd_ok & rd_bank_q;
  assign we0   = we_q & ~rst & ~wr_bank_q;
  assign we1   = we_q & ~rst & wr_bank_q;

  mem_single #(
    .DW    (DW),
    .DEPTH (NPIX),
    .AW    (AW)
  ) u_bank0 (
    .clk     (clk),
    .we_i    (we0),
    .waddr_i (waddr_q),
    .wdata_i (wdata_q),
    .re_i    (re0),
    .raddr_i (rd_addr),
    .rdata_o (rdata0)
  );

  mem_single #(
    .DW    (DW),
    .DEPTH (NPIX),
    .AW    (AW)
  ) u_bank1 (
    .clk     (clk),
    .we_i    (we1),
    .waddr_i (waddr_q),
    .wdata_i (wdata_q),
    .re_i    (re1),
    .raddr_i (rd_addr),
    .rdata_o (rdata1)
  );

  assign rd_data   = rd_sel_q ? rdata1 : rdata0;
  assign start     = start_q;
  assign o_ovf     = ovf_q;
  assign o_sof_err = sof_err_q;

endmodule

// File: tb/tb_filter2d_pp_buf.sv
// Bench for filter2d_pp_buf on a 4x3 image against a frame-level model
// that tracks a linear pixel index and per-bank full flags.

module tb_filter2d_pp_buf;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_strb = 1'b0;
  logic          i_sof = 1'b0;
  logic [7:0]    i_data = '0;
  logic          i_rdy;
  logic          start;
  logic          mem_rd = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_data;
  logic          rd_done = 1'b0;
  logic          o_ovf;
  logic          o_sof_err;

  always #5 clk = ~clk;

  filter2d_pp_buf #(
    .DW    (8),
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_strb    (i_strb),
    .i_sof     (i_sof),
    .i_data    (i_data),
    .i_rdy     (i_rdy),
    .start     (start),
    .mem_rd    (mem_rd),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_done   (rd_done),
    .o_ovf     (o_ovf),
    .o_sof_err (o_sof_err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] m_mem [2][N];
  bit [1:0]   m_full;
  bit         m_wr, m_rd, m_pend;
  int         m_p;
  bit         m_ovf, m_sof_err, m_start;
  bit         m_rdv;
  logic [7:0] m_rdd;

  function automatic bit m_rdy();
    return !m_full[m_wr] && !m_pend;
  endfunction

  task automatic model_reset();
    m_full = '0; m_wr = 0; m_rd = 0;
    m_pend = 0; m_p = 0; m_ovf = 0;
    m_sof_err = 0; m_start = 0; m_rdv = 0;
  endtask

  task automatic model_step(input bit s, input bit sof,
                            input logic [7:0] d, input bit rd,
                            input int a, input bit done);
    bit [1:0] f0;
    bit r0, rdy;
    f0 = m_full; r0 = m_rd; rdy = m_rdy();
    m_rdv = rd && f0[r0];
    if (m_rdv) m_rdd = m_mem[r0][a];
    if (s && !rdy) m_ovf = 1;
    if (m_pend) begin
      m_full[m_wr] = 1; m_wr = !m_wr; m_pend = 0;
    end
    if (done && f0[r0]) begin
      m_full[r0] = 0; m_rd = !r0;
    end
    if (s && rdy) begin
      if (sof && m_p != 0) begin
        m_mem[m_wr][0] = d; m_p = 1; m_sof_err = 1;
      end else begin
        m_mem[m_wr][m_p] = d;
        if (m_p == N - 1) begin
          m_p = 0; m_pend = 1;
        end else m_p++;
      end
    end
    m_start = m_full[m_rd] && !(m_rd == r0 && f0[r0]);
  endtask

  task automatic cycle(input bit s, input bit sof,
                       input logic [7:0] d, input bit rd,
                       input int a, input bit done);
    i_strb = s; i_sof = sof; i_data = d;
    mem_rd = rd; rd_addr = a[AW-1:0]; rd_done = done;
    model_step(s, sof, d, rd, a, done);
    @(posedge clk); #1;
    i_strb = 0; i_sof = 0; mem_rd = 0; rd_done = 0;
  endtask

  task automatic idle();
    cycle(0, 0, 8'h00, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1; i_strb = 0; i_sof = 0;
    mem_rd = 0; rd_done = 0;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  task automatic send_frame(input int base, input bit rnd);
    for (int i = 0; i < N; i++)
      cycle(1, 0, rnd ? 8'($urandom) : 8'(base + i), 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if (start !== 1'b0) $display("FAIL reset_start got %b exp 0", start);
    else n_pass++;
    n_chk++;
    if (o_ovf !== 1'b0) $display("FAIL reset_ovf got %b exp 0", o_ovf);
    else n_pass++;
    n_chk++;
    if (o_sof_err !== 1'b0)
      $display("FAIL reset_sof_err got %b exp 0", o_sof_err);
    else n_pass++;
    n_chk++;
    if (i_rdy !== 1'b1) $display("FAIL reset_rdy got %b exp 1", i_rdy);
    else n_pass++;
  endtask

  task automatic test_single_frame();
    do_reset();
    for (int i = 0; i < N; i++) begin
      n_chk++;
      if (i_rdy !== 1'b1) $display("FAIL sf_rdy[%0d] got %b exp 1", i, i_rdy);
      else n_pass++;
      cycle(1, 0, 8'(i), 0, 0, 0);
    end
    n_chk++;
    if (start !== 1'b0 || i_rdy !== 1'b0)
      $display("FAIL sf_bubble start=%b rdy=%b exp 0,0", start, i_rdy);
    else n_pass++;
    idle();
    n_chk++;
    if (start !== 1'b1) $display("FAIL sf_start got %b exp 1", start);
    else n_pass++;
    idle();
    n_chk++;
    if (start !== 1'b0) $display("FAIL sf_pulse got %b exp 0", start);
    else n_pass++;
    for (int i = 0; i < N; i++) begin
      cycle(0, 0, 8'h00, 1, i, 0);
      n_chk++;
      if (rd_data !== 8'(i))
        $display("FAIL sf_rd[%0d] got %0d exp %0d", i, rd_data, i);
      else n_pass++;
    end
  endtask

  task automatic test_both_full();
    do_reset();
    send_frame(0, 0); idle(); idle();
    send_frame(100, 0); idle(); idle();
    n_chk++;
    if (i_rdy !== 1'b0) $display("FAIL bf_rdy got %b exp 0", i_rdy);
    else n_pass++;
    n_chk++;
    if (start !== m_start)
      $display("FAIL bf_nostart got %b exp %b", start, m_start);
    else n_pass++;
    cycle(1, 0, 8'hAA, 0, 0, 0);
    n_chk++;
    if (o_ovf !== 1'b1) $display("FAIL bf_ovf got %b exp 1", o_ovf);
    else n_pass++;
    cycle(0, 0, 8'h00, 0, 0, 1);
    n_chk++;
    if (start !== 1'b1) $display("FAIL bf_start got %b exp 1", start);
    else n_pass++;
    for (int i = 0; i < N; i++) begin
      cycle(0, 0, 8'h00, 1, i, 0);
      n_chk++;
      if (rd_data !== 8'(100 + i))
        $display("FAIL bf_rd[%0d] got %0d exp %0d", i, rd_data, 100 + i);
      else n_pass++;
    end
  endtask

  task automatic test_release_resume();
    do_reset();
    send_frame(0, 1); idle(); idle();
    send_frame(0, 1); idle(); idle();
    n_chk++;
    if (i_rdy !== 1'b0) $display("FAIL rr_stall got %b exp 0", i_rdy);
    else n_pass++;
    cycle(0, 0, 8'h00, 0, 0, 1);
    n_chk++;
    if (i_rdy !== 1'b1 || start !== 1'b1)
      $display("FAIL rr_release rdy=%b start=%b exp 1,1", i_rdy, start);
    else n_pass++;
    for (int i = 0; i < N; i++) begin
      n_chk++;
      if (i_rdy !== 1'b1) $display("FAIL rr_rdy[%0d] got %b exp 1", i, i_rdy);
      else n_pass++;
      cycle(1, 0, 8'($urandom), 0, 0, 0);
    end
    idle(); idle();
    n_chk++;
    if (o_ovf !== 1'b0) $display("FAIL rr_ovf got %b exp 0", o_ovf);
    else n_pass++;
    n_chk++;
    if (i_rdy !== m_rdy()) $display("FAIL rr_full got %b exp %b", i_rdy, m_rdy());
    else n_pass++;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < N; i++) begin
        cycle(0, 0, 8'h00, 1, i, 0);
        n_chk++;
        if (rd_data !== m_rdd)
          $display("FAIL rr_rd%0d[%0d] got %0d exp %0d", pass, i, rd_data, m_rdd);
        else n_pass++;
      end
      cycle(0, 0, 8'h00, 0, 0, 1);
      n_chk++;
      if (start !== m_start)
        $display("FAIL rr_start%0d got %b exp %b", pass, start, m_start);
      else n_pass++;
    end
  endtask

  task automatic test_sof_mid();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 0, 8'($urandom), 0, 0, 0);
    cycle(1, 1, 8'd50, 0, 0, 0);
    n_chk++;
    if (o_sof_err !== 1'b1) $display("FAIL sof_err got %b exp 1", o_sof_err);
    else n_pass++;
    for (int i = 0; i < N - 1; i++) begin
      n_chk++;
      if (start !== 1'b0) $display("FAIL sof_early[%0d] got %b exp 0", i, start);
      else n_pass++;
      cycle(1, 0, 8'($urandom), 0, 0, 0);
    end
    idle();
    n_chk++;
    if (start !== 1'b1) $display("FAIL sof_start got %b exp 1", start);
    else n_pass++;
    cycle(0, 0, 8'h00, 1, 0, 0);
    n_chk++;
    if (rd_data !== 8'd50) $display("FAIL sof_rd0 got %0d exp 50", rd_data);
    else n_pass++;
    for (int i = 1; i < N; i++) begin
      cycle(0, 0, 8'h00, 1, i, 0);
      n_chk++;
      if (rd_data !== m_rdd)
        $display("FAIL sof_rd[%0d] got %0d exp %0d", i, rd_data, m_rdd);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 7; i++) cycle(1, i == 3, 8'($urandom), 0, 0, 0);
    n_chk++;
    if (o_sof_err !== 1'b1) $display("FAIL rm_pre got %b exp 1", o_sof_err);
    else n_pass++;
    i_strb = 1;
    do_reset();
    n_chk++;
    if (start !== 1'b0 || o_ovf !== 1'b0 || o_sof_err !== 1'b0 || i_rdy !== 1'b1)
      $display("FAIL rm_state start=%b ovf=%b sof=%b rdy=%b exp 0,0,0,1",
               start, o_ovf, o_sof_err, i_rdy);
    else n_pass++;
    send_frame(0, 1); idle();
    n_chk++;
    if (start !== 1'b1) $display("FAIL rm_start got %b exp 1", start);
    else n_pass++;
    for (int i = 0; i < N; i++) begin
      cycle(0, 0, 8'h00, 1, i, 0);
      n_chk++;
      if (rd_data !== m_mem[0][i])
        $display("FAIL rm_rd[%0d] got %0d exp %0d", i, rd_data, m_mem[0][i]);
      else n_pass++;
    end
  endtask

  task automatic test_ignored_reads();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 8'h00, 1, i, i % 2 == 0);
      n_chk++;
      if (start !== 1'b0 || i_rdy !== 1'b1)
        $display("FAIL ig[%0d] start=%b rdy=%b exp 0,1", i, start, i_rdy);
      else n_pass++;
    end
    send_frame(0, 1); idle();
    n_chk++;
    if (start !== 1'b1) $display("FAIL ig_start got %b exp 1", start);
    else n_pass++;
    cycle(0, 0, 8'h00, 1, 5, 0);
    n_chk++;
    if (rd_data !== m_mem[0][5])
      $display("FAIL ig_rd got %0d exp %0d", rd_data, m_mem[0][5]);
    else n_pass++;
  endtask

  task automatic test_random_soak();
    bit s, sof, rd, done;
    int a;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      s    = $urandom_range(0, 3) != 0;
      sof  = $urandom_range(0, 40) == 0;
      rd   = $urandom_range(0, 1) == 1;
      a    = $urandom_range(0, N - 1);
      done = $urandom_range(0, 12) == 0;
      cycle(s, sof, 8'($urandom), rd, a, done);
      n_chk++;
      if (start !== m_start || i_rdy !== m_rdy())
        $display("FAIL soak_ctl[%0d] start=%b rdy=%b exp %b,%b",
                 c, start, i_rdy, m_start, m_rdy());
      else n_pass++;
      n_chk++;
      if (o_ovf !== m_ovf || o_sof_err !== m_sof_err)
        $display("FAIL soak_flags[%0d] ovf=%b sof=%b exp %b,%b",
                 c, o_ovf, o_sof_err, m_ovf, m_sof_err);
      else n_pass++;
      if (m_rdv) begin
        n_chk++;
        if (rd_data !== m_rdd)
          $display("FAIL soak_rd[%0d] got %0d exp %0d", c, rd_data, m_rdd);
        else n_pass++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_frame();
    test_both_full();
    test_release_resume();
    test_sof_mid();
    test_reset_mid();
    test_ignored_reads();
    test_random_soak();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
